sync_fifo_rdy_ack_ext: RTL and testbench

SYNC_FIFO_RDY_ACK_EXT -- requirements
Module: sync_fifo_rdy_ack_ext

---
 rtl/sync_fifo_rdy_ack_ext.sv | 107 ++++++++++
 tb/tb_sync_fifo_rdy_ack_ext.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_rdy_ack_ext.sv
// rtl/sync_fifo_rdy_ack_ext.sv - circular-buffer FIFO with registered output stage and rdy/ack handshakes
module sync_fifo_rdy_ack_ext #(
   parameter int DP_M1     = 7,
   parameter int DW_M1     = 7,
   parameter int AW_M1     = 3,
   parameter int AFULL_TH  = 6,
   parameter int AEMPTY_TH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             i_rdy,
   output logic             i_ack,
   input  logic [DW_M1:0]   i_data,
   output logic             o_rdy,
   input  logic             o_ack,
   output logic [DW_M1:0]   o_data,
   output logic [AW_M1:0]   level,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty
);

   localparam int DP = DP_M1 + 1;
   localparam int DW = DW_M1 + 1;
   localparam int AW = AW_M1 + 1;
   // Pointer width only needs to address DP entries; keep at least one bit for DP == 1.
   localparam int PW = (DP > 1) ? $clog2(DP) : 1;

   localparam logic [PW-1:0] PTR_LAST  = PW'(DP_M1);
   localparam logic [AW-1:0] LVL_DP    = AW'(DP);
   localparam logic [AW-1:0] LVL_AFULL = AW'(AFULL_TH);
   localparam logic [AW-1:0] LVL_AEMPT = AW'(AEMPTY_TH);
   localparam logic [AW-1:0] LVL_ONE   = AW'(1);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);

   logic [DW-1:0] mem [DP];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [AW-1:0] level_q;
   logic          o_rdy_q;
   logic          wr;
   logic          rd;

   // Status flags are decoded straight from the registered occupancy.
   always_comb begin
      full         = (level_q == LVL_DP);
      empty        = (level_q == '0);
      almost_full  = (level_q >= LVL_AFULL);
      almost_empty = (level_q <= LVL_AEMPT);
   end

   // Handshake decode: acceptance never looks at o_ack, so a full FIFO stalls upstream
   // even when the output register is being drained in the same cycle.
   always_comb begin
      i_ack = !full && !flush;
      wr    = i_rdy && i_ack;
      rd    = !empty && !flush && (!o_rdy_q || o_ack);
   end

   assign level = level_q;
   assign o_rdy = o_rdy_q;

   // Pointers, occupancy and output-valid; flush clears everything and suppresses both ports.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         o_rdy_q <= 1'b0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         o_rdy_q <= 1'b0;
      end else begin
         if (wr) begin
            wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
         end
         if (rd) begin
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
         end
         case ({wr, rd})
            2'b10:   level_q <= level_q + LVL_ONE;
            2'b01:   level_q <= level_q - LVL_ONE;
            default: level_q <= level_q;
         endcase
         if (rd) begin
            o_rdy_q <= 1'b1;
         end else if (o_rdy_q && o_ack) begin
            o_rdy_q <= 1'b0;
         end
      end
   end

   // Storage array and output data register carry no reset; validity is tracked by level and o_rdy.
   always_ff @(posedge clk) begin
      if (wr) begin
         mem[wr_ptr] <= i_data;
      end
      if (rd) begin
         o_data <= mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_sync_fifo_rdy_ack_ext.sv
// tb/tb_sync_fifo_rdy_ack_ext.sv - randomized and directed bench for sync_fifo_rdy_ack_ext
module tb_sync_fifo_rdy_ack_ext;

   localparam int DP = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       i_rdy = 1'b0;
   logic       o_ack = 1'b0;
   logic [7:0] i_data = 8'h00;
   logic       i_ack;
   logic       o_rdy;
   logic [7:0] o_data;
   logic [3:0] level;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;

   int n_cmp = 0;
   int n_fail = 0;

   // Reference model: queue of memory contents plus the output register.
   logic [7:0] mq[$];
   bit         m_ov = 1'b0;
   logic [7:0] m_od = 8'h00;

   sync_fifo_rdy_ack_ext #(
      .DP_M1(7), .DW_M1(7), .AW_M1(3), .AFULL_TH(6), .AEMPTY_TH(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .i_rdy(i_rdy), .i_ack(i_ack), .i_data(i_data),
      .o_rdy(o_rdy), .o_ack(o_ack), .o_data(o_data),
      .level(level), .full(full), .empty(empty),
      .almost_full(almost_full), .almost_empty(almost_empty)
   );

   always #5 clk = ~clk;

   // Expected {full, empty, almost_full, almost_empty} for an occupancy.
   function automatic logic [3:0] exp_flags(input int lv);
      return {lv == DP, lv == 0, lv >= 6, lv <= 1};
   endfunction

   task automatic model_clear;
      mq.delete();
      m_ov = 1'b0;
   endtask

   task automatic model_edge(input bit f, input bit ir, input bit oa, input logic [7:0] d);
      bit acc;
      bit pop;
      acc = ir && !f && (mq.size() < DP);
      pop = !f && (mq.size() > 0) && (!m_ov || oa);
      if (f) begin
         model_clear();
      end else begin
         if (pop) begin
            m_od = mq.pop_front();
            m_ov = 1'b1;
         end else if (m_ov && oa) begin
            m_ov = 1'b0;
         end
         if (acc) mq.push_back(d);
      end
   endtask

   task automatic drive_edge(input bit f, input bit ir, input bit oa, input logic [7:0] d);
      flush  = f;
      i_rdy  = ir;
      o_ack  = oa;
      i_data = d;
      model_edge(f, ir, oa, d);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2;
      n_cmp++;
      if ({o_rdy, level, full, empty, almost_full, almost_empty, i_ack} !== {1'b0, 4'd0, 4'b0101, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state: got rdy=%0b lvl=%0d flags=%b iack=%0b, want rdy=0 lvl=0 flags=0101 iack=1",
                  o_rdy, level, {full, empty, almost_full, almost_empty}, i_ack);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill;
      int acc = 0;
      for (int c = 0; c < 20 && i_ack; c++) begin
         drive_edge(1'b0, 1'b1, 1'b0, 8'(acc));
         acc++;
      end
      i_rdy = 1'b0;
      #1;
      n_cmp++;
      if (acc !== 9) begin
         n_fail++;
         $display("FAIL fill_count: accepted %0d, want 9", acc);
      end
      n_cmp++;
      if ({o_rdy, o_data, level, full, i_ack} !== {1'b1, 8'h00, 4'd8, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL fill_state: got rdy=%0b data=%0h lvl=%0d full=%0b iack=%0b, want 1 0 8 1 0",
                  o_rdy, o_data, level, full, i_ack);
      end
   endtask

   task automatic test_drain;
      for (int k = 0; k < 9; k++) begin
         n_cmp++;
         if ({o_rdy, o_data} !== {1'b1, 8'(k)}) begin
            n_fail++;
            $display("FAIL drain_seq[%0d]: got rdy=%0b data=%0h, want rdy=1 data=%0h", k, o_rdy, o_data, k);
         end
         drive_edge(1'b0, 1'b0, 1'b1, 8'h00);
      end
      o_ack = 1'b0;
      n_cmp++;
      if ({o_rdy, level, empty} !== {1'b0, 4'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL drain_end: got rdy=%0b lvl=%0d empty=%0b, want 0 0 1", o_rdy, level, empty);
      end
   endtask

   task automatic test_latency;
      drive_edge(1'b0, 1'b1, 1'b0, 8'hA5);
      i_rdy = 1'b0;
      n_cmp++;
      if ({o_rdy, level} !== {1'b0, 4'd1}) begin
         n_fail++;
         $display("FAIL latency_edge1: got rdy=%0b lvl=%0d, want rdy=0 lvl=1", o_rdy, level);
      end
      drive_edge(1'b0, 1'b0, 1'b0, 8'h00);
      n_cmp++;
      if ({o_rdy, o_data, level} !== {1'b1, 8'hA5, 4'd0}) begin
         n_fail++;
         $display("FAIL latency_edge2: got rdy=%0b data=%0h lvl=%0d, want 1 a5 0", o_rdy, o_data, level);
      end
      drive_edge(1'b0, 1'b0, 1'b1, 8'h00);
      o_ack = 1'b0;
      n_cmp++;
      if (o_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_consume: got rdy=%0b, want 0", o_rdy);
      end
   endtask

   task automatic test_flags;
      for (int c = 0; c < 12; c++) begin
         drive_edge(1'b0, 1'b1, 1'b0, 8'($urandom));
         n_cmp++;
         if ({level, full, empty, almost_full, almost_empty} !== {4'(mq.size()), exp_flags(mq.size())}) begin
            n_fail++;
            $display("FAIL flags[%0d]: got lvl=%0d flags=%b, want lvl=%0d flags=%b", c, level,
                     {full, empty, almost_full, almost_empty}, mq.size(), exp_flags(mq.size()));
         end
      end
      i_rdy = 1'b0;
   endtask

   task automatic test_wrap;
      for (int c = 0; c < 24; c++) begin
         drive_edge(1'b0, 1'b1, 1'b1, 8'($urandom));
         n_cmp++;
         if ({o_rdy, level} !== {m_ov, 4'(mq.size())} || (m_ov && o_data !== m_od)) begin
            n_fail++;
            $display("FAIL wrap[%0d]: got rdy=%0b lvl=%0d data=%0h, want rdy=%0b lvl=%0d data=%0h",
                     c, o_rdy, level, o_data, m_ov, mq.size(), m_od);
         end
      end
      i_rdy = 1'b0;
   endtask

   task automatic test_flush;
      drive_edge(1'b0, 1'b1, 1'b0, 8'h11);
      drive_edge(1'b0, 1'b1, 1'b0, 8'h22);
      drive_edge(1'b0, 1'b1, 1'b0, 8'h33);
      flush = 1'b1;
      i_rdy = 1'b1;
      o_ack = 1'b1;
      #1;
      n_cmp++;
      if (i_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_iack: got %0b, want 0", i_ack);
      end
      drive_edge(1'b1, 1'b1, 1'b1, 8'h44);
      flush = 1'b0;
      n_cmp++;
      if ({o_rdy, level, empty} !== {1'b0, 4'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL flush_state: got rdy=%0b lvl=%0d empty=%0b, want 0 0 1", o_rdy, level, empty);
      end
      drive_edge(1'b0, 1'b0, 1'b0, 8'h00);
      n_cmp++;
      if ({o_rdy, level} !== {1'b0, 4'd0}) begin
         n_fail++;
         $display("FAIL flush_nowrite: got rdy=%0b lvl=%0d, want 0 0", o_rdy, level);
      end
   endtask

   task automatic test_random;
      int  xfers = 0;
      bit  did_reset = 1'b0;
      bit  f;
      bit  ir;
      bit  oa;
      logic [7:0] d;
      for (int c = 0; c < 20000 && xfers < 1000; c++) begin
         f  = ($urandom_range(0, 149) == 0);
         ir = ($urandom_range(0, 3) != 0);
         oa = ($urandom_range(0, 2) != 0);
         d  = 8'($urandom);
         flush  = f;
         i_rdy  = ir;
         o_ack  = oa;
         i_data = d;
         #1;
         n_cmp++;
         if ({o_rdy, level, full, empty, almost_full, almost_empty, i_ack} !==
             {m_ov, 4'(mq.size()), exp_flags(mq.size()), !f && (mq.size() < DP)} ||
             (m_ov && o_data !== m_od)) begin
            n_fail++;
            $display("FAIL random[%0d]: got rdy=%0b lvl=%0d data=%0h iack=%0b, want rdy=%0b lvl=%0d data=%0h",
                     c, o_rdy, level, o_data, i_ack, m_ov, mq.size(), m_od);
         end
         if (m_ov && oa && !f) xfers++;
         model_edge(f, ir, oa, d);
         @(posedge clk);
         #1;
         if (!did_reset && xfers >= 500) begin
            did_reset = 1'b1;
            #2;
            rst_n = 1'b0;
            flush = 1'b0;
            #1;
            n_cmp++;
            if ({o_rdy, level, full, empty, almost_full, almost_empty, i_ack} !== {1'b0, 4'd0, 4'b0101, 1'b1}) begin
               n_fail++;
               $display("FAIL midrun_reset: got rdy=%0b lvl=%0d flags=%b iack=%0b, want 0 0 0101 1",
                        o_rdy, level, {full, empty, almost_full, almost_empty}, i_ack);
            end
            model_clear();
            @(negedge clk);
            rst_n = 1'b1;
            i_rdy = 1'b0;
            o_ack = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      n_cmp++;
      if (xfers < 1000 || !did_reset) begin
         n_fail++;
         $display("FAIL random_budget: transfers=%0d reset_done=%0b, want 1000 and 1", xfers, did_reset);
      end
      flush = 1'b0;
      i_rdy = 1'b0;
      o_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_latency();
      test_flags();
      test_wrap();
      test_flush();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
